list_writer: RTL and testbench
==============================

Name: list_writer

Overview:
- Writer end of the linked-list sum path. It builds a null-terminated linked list in word-addressed memory from a stream of values.
- The existing sum controller and its datapath traverse that list and sum it.
- Node layout is shared with the traversal side:
  - word at node address = value
  - word at node address+1 = next-node pointer
  - pointer 0 = null, which marks the end of the list
- Sits between a producer (valid/ready stream) and the node memory's write port.

Parameters:
W, 8, data width = address width = pointer width (one memory word holds either a value or a pointer)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  level; begin building a list at base_addr (sampled in IDLE)
base_addr  input  W  address of the first node; sampled with start
in_valid  input  1  producer has an element
in_data  input  W  element value
in_last  input  1  element is the final one of the list
in_ready  output  1  writer can accept an element this cycle
mem_we  output  1  memory write strobe, one word per cycle
mem_addr  output  W  write address
mem_wdata  output  W  write data
done  output  1  list complete; held while in DONE
err  output  1  valid with done: bad base or address-space overflow
head  output  W  base address of the list just built (valid with done)
count  output  W  number of nodes written (valid with done)

Behaviour:
- Reset (async, rst=1): state=IDLE. in_ready, mem_we, done and err are 0. mem_addr, mem_wdata, head and count are 0. Internal cur pointer is 0.
- Reset mid-operation aborts immediately. The memory contents of a partial list are undefined; no terminator is guaranteed.
- Moore FSM with states IDLE, ACCEPT, WR_VAL, WR_NEXT, DONE. All outputs decode from state and registers only.
- IDLE, start=1 with a bad base (base_addr==0 or base_addr==2^W-1):
  - go to DONE with err=1, count=0, no writes.
- IDLE, start=1 with a good base:
  - cur<=base_addr, head<=base_addr, count<=0, err<=0, go to ACCEPT.
- IDLE, start=0: stay in IDLE.
- ACCEPT:
  - in_ready=1.
  - On in_valid=1: latch in_data and in_last, go to WR_VAL.
  - Otherwise stay in ACCEPT (unbounded wait, no writes).
- WR_VAL: mem_we=1, mem_addr=cur, mem_wdata=latched value. Always go to WR_NEXT.
- WR_NEXT: mem_we=1, mem_addr=cur+1. count<=count+1.
  - Latched last=1: mem_wdata=0, go to DONE.
  - Latched last=0 and cur>2^W-4 (the next node would not fit): mem_wdata=0, err<=1, go to DONE. This forces termination.
  - Otherwise: mem_wdata=cur+2, cur<=cur+2, go to ACCEPT.
- DONE: done=1 and in_ready=0. Stay while start=1; go to IDLE when start=0. This matches the traversal controller's start/done handshake.
- Timing:
  - Throughput is 3 cycles per element minimum (ACCEPT, WR_VAL, WR_NEXT).
  - The first write occurs 2 cycles after start is sampled if in_valid is already high.
  - done rises the cycle after the terminator write.
- Address arithmetic is modulo 2^W. The overflow check prevents any wrap into address 0.
- Every list contains at least one element; an empty list is not representable.
- in_data and in_last are ignored outside the ACCEPT handshake.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..DONE)
  - NULL_PTR=0
  - NODE_STRIDE=2
  - node word offsets VAL_OFS=0 and NXT_OFS=1
- The sum controller and datapath use the same package so the layout stays consistent.
- Single flat module; no sub-module is warranted.

Test Plan:
- base=0x10, values 5,7,9 with last on 9, in_valid always high:
  - expected writes: (0x10,5) (0x11,0x12) (0x12,7) (0x13,0x14) (0x14,9) (0x15,0)
  - then done=1, err=0, head=0x10, count=3.
- base=0x40, single value 0xAA with last:
  - expected writes: (0x40,0xAA) (0x41,0x00)
  - done 1 cycle later, count=1.
- Backpressure: in_valid low for 4 cycles in ACCEPT -> in_ready stays 1, mem_we stays 0 for all 4 cycles; the list resumes correctly afterwards.
- Overflow: base=0xFA, 4 values with no last:
  - nodes at 0xFA and 0xFC are linked; the node at 0xFE is written as (0xFE,v) (0xFF,0)
  - result: done=1, err=1, count=3, and the 4th value is not accepted.
- base=0x00 or base=0xFF with start=1 -> DONE next cycle with err=1, count=0, and no mem_we pulse.
- Start handling and mid-operation reset:
  - start held high in DONE keeps done=1; start low returns to IDLE and done clears next cycle.
  - rst asserted during WR_VAL drops mem_we and all outputs to 0 immediately (asynchronous).

Source files
------------

// File: rtl/list_writer_pkg.sv
// Shared linked-list node layout and writer state encoding.
package list_writer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    WR_VAL  = 3'd2,
    WR_NEXT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Pointer value that terminates a list.
  localparam int unsigned NULL_PTR    = 0;
  // Words occupied by one node.
  localparam int unsigned NODE_STRIDE = 2;
  // Word offsets of the value and next-pointer fields within a node.
  localparam int unsigned VAL_OFS     = 0;
  localparam int unsigned NXT_OFS     = 1;

endpackage

// File: rtl/list_writer.sv
// Builds a null-terminated linked list in word memory from a valid/ready stream.
module list_writer
  import list_writer_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base_addr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         done,
  output logic         err,
  output logic [W-1:0] head,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ADDR_MAX = {W{1'b1}};
  // Highest node address whose successor node still fits below ADDR_MAX.
  localparam logic [W-1:0] LAST_FIT = ADDR_MAX - W'(NODE_STRIDE + 1);

  state_t       state, state_d;
  logic [W-1:0] cur, cur_d;
  logic [W-1:0] val_q, val_d;
  logic         last_q, last_d;
  logic [W-1:0] head_d, count_d;
  logic         err_d;
  logic         in_ready_d, mem_we_d, done_d;
  logic [W-1:0] mem_addr_d, mem_wdata_d;
  logic         bad_base;

  assign bad_base = (base_addr == W'(NULL_PTR)) || (base_addr == ADDR_MAX);

  // State and output registers; outputs are loaded with the decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      val_q     <= '0;
      last_q    <= 1'b0;
      head      <= '0;
      count     <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cur       <= cur_d;
      val_q     <= val_d;
      last_q    <= last_d;
      head      <= head_d;
      count     <= count_d;
      err       <= err_d;
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      done      <= done_d;
    end
  end

  // Next-state/register update, then Moore output decode of the next state.
  always_comb begin
    state_d     = state;
    cur_d       = cur;
    val_d       = val_q;
    last_d      = last_q;
    head_d      = head;
    count_d     = count;
    err_d       = err;
    in_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    done_d      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          head_d  = base_addr;
          count_d = '0;
          if (bad_base) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cur_d   = base_addr;
            err_d   = 1'b0;
            state_d = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          val_d   = in_data;
          last_d  = in_last;
          state_d = WR_VAL;
        end
      end
      WR_VAL: state_d = WR_NEXT;
      WR_NEXT: begin
        count_d = count + W'(1);
        if (last_q) begin
          state_d = DONE;
        end else if (cur > LAST_FIT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cur_d   = cur + W'(NODE_STRIDE);
          state_d = ACCEPT;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      ACCEPT: in_ready_d = 1'b1;
      WR_VAL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cur_d + W'(VAL_OFS);
        mem_wdata_d = val_d;
      end
      WR_NEXT: begin
        mem_we_d   = 1'b1;
        mem_addr_d = cur_d + W'(NXT_OFS);
        // Terminate on the final element or when the next node would not fit.
        if (last_d || (cur_d > LAST_FIT)) mem_wdata_d = W'(NULL_PTR);
        else                              mem_wdata_d = cur_d + W'(NODE_STRIDE);
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_list_writer.sv
// Directed self-checking bench for list_writer.
module tb_list_writer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       done;
  logic       err;
  logic [7:0] head;
  logic [7:0] count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] vals[8];
  logic [7:0] ea[8];
  logic [7:0] ed[8];

  list_writer #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done), .err(err), .head(head), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every memory write mid-cycle.
  always @(negedge clk) begin
    if (mem_we && !rst) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr"}, 32'(wa.size()), 32'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(ea[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(ed[i]));
    end
  endtask

  // Feed vals[0..n-1] with in_valid high until done; reports accepted count.
  task automatic run_list(input logic [7:0] base, input int n, input bit with_last,
                          output int accepted, output bit term_prev);
    int cyc;
    bit hs;
    bit prev_we;
    wa.delete();
    wd.delete();
    accepted  = 0;
    prev_we   = 1'b0;
    base_addr = base;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_data   = vals[0];
    in_last   = with_last && (n == 1);
    cyc       = 0;
    while (!done && cyc < 200) begin
      hs      = in_ready && in_valid;
      prev_we = mem_we;
      step();
      cyc++;
      if (hs) begin
        accepted++;
        if (accepted < n) begin
          in_data = vals[accepted];
          in_last = with_last && (accepted == n - 1);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("run_done", 32'(done), 32'd1);
    term_prev = prev_we;
    in_valid  = 1'b0;
  endtask

  initial begin
    int  acc;
    bit  tp;

    rst = 1'b1; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata",    32'(mem_wdata),32'd0);
    chk("rst_head",     32'(head),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Three-element list at 0x10.
    vals[0] = 8'd5; vals[1] = 8'd7; vals[2] = 8'd9;
    ea[0] = 8'h10; ed[0] = 8'd5;
    ea[1] = 8'h11; ed[1] = 8'h12;
    ea[2] = 8'h12; ed[2] = 8'd7;
    ea[3] = 8'h13; ed[3] = 8'h14;
    ea[4] = 8'h14; ed[4] = 8'd9;
    ea[5] = 8'h15; ed[5] = 8'h00;
    run_list(8'h10, 3, 1'b1, acc, tp);
    chk("l3_accepted", 32'(acc), 32'd3);
    chk("l3_done_after_term", 32'(tp), 32'd1);
    chk("l3_err",   32'(err),   32'd0);
    chk("l3_head",  32'(head),  32'h10);
    chk("l3_count", 32'(count), 32'd3);
    check_writes("l3", 6);
    step();
    chk("hold_done1", 32'(done), 32'd1);
    step();
    chk("hold_done2", 32'(done), 32'd1);
    start = 1'b0;
    step();
    chk("release_done",  32'(done),     32'd0);
    chk("release_ready", 32'(in_ready), 32'd0);

    // Single-element list at 0x40.
    vals[0] = 8'hAA;
    ea[0] = 8'h40; ed[0] = 8'hAA;
    ea[1] = 8'h41; ed[1] = 8'h00;
    run_list(8'h40, 1, 1'b1, acc, tp);
    chk("l1_done_after_term", 32'(tp), 32'd1);
    chk("l1_err",   32'(err),   32'd0);
    chk("l1_head",  32'(head),  32'h40);
    chk("l1_count", 32'(count), 32'd1);
    check_writes("l1", 2);
    start = 1'b0;
    step();

    // Backpressure: producer idle for 4 cycles in ACCEPT.
    wa.delete(); wd.delete();
    base_addr = 8'h30; start = 1'b1; in_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_ready%0d", i), 32'(in_ready), 32'd1);
      chk($sformatf("bp_we%0d", i),    32'(mem_we),   32'd0);
      step();
    end
    chk("bp_nowrites", 32'(wa.size()), 32'd0);
    vals[0] = 8'h11; vals[1] = 8'h22;
    ea[0] = 8'h30; ed[0] = 8'h11;
    ea[1] = 8'h31; ed[1] = 8'h32;
    ea[2] = 8'h32; ed[2] = 8'h22;
    ea[3] = 8'h33; ed[3] = 8'h00;
    run_list(8'h30, 2, 1'b1, acc, tp);
    chk("bp_count", 32'(count), 32'd2);
    chk("bp_err",   32'(err),   32'd0);
    check_writes("bp", 4);
    start = 1'b0;
    step();

    // Address-space overflow from base 0xFA, no last flag.
    vals[0] = 8'd1; vals[1] = 8'd2; vals[2] = 8'd3; vals[3] = 8'd4;
    ea[0] = 8'hFA; ed[0] = 8'd1;
    ea[1] = 8'hFB; ed[1] = 8'hFC;
    ea[2] = 8'hFC; ed[2] = 8'd2;
    ea[3] = 8'hFD; ed[3] = 8'hFE;
    ea[4] = 8'hFE; ed[4] = 8'd3;
    ea[5] = 8'hFF; ed[5] = 8'h00;
    run_list(8'hFA, 4, 1'b0, acc, tp);
    chk("ov_accepted", 32'(acc),   32'd3);
    chk("ov_err",      32'(err),   32'd1);
    chk("ov_count",    32'(count), 32'd3);
    chk("ov_head",     32'(head),  32'hFA);
    check_writes("ov", 6);
    start = 1'b0;
    step();

    // Bad base addresses.
    for (int k = 0; k < 2; k++) begin
      wa.delete(); wd.delete();
      base_addr = (k == 0) ? 8'h00 : 8'hFF;
      start = 1'b1;
      step();
      chk($sformatf("bad%0d_done", k),  32'(done),   32'd1);
      chk($sformatf("bad%0d_err", k),   32'(err),    32'd1);
      chk($sformatf("bad%0d_count", k), 32'(count),  32'd0);
      chk($sformatf("bad%0d_we", k),    32'(mem_we), 32'd0);
      step();
      chk($sformatf("bad%0d_nowr", k),  32'(wa.size()), 32'd0);
      start = 1'b0;
      step();
      chk($sformatf("bad%0d_clear", k), 32'(done), 32'd0);
    end

    // Asynchronous reset during WR_VAL.
    base_addr = 8'h50; start = 1'b1; in_valid = 1'b1; in_data = 8'h33; in_last = 1'b0;
    step();
    chk("mr_ready", 32'(in_ready), 32'd1);
    step();
    chk("mr_we",    32'(mem_we),    32'd1);
    chk("mr_addr",  32'(mem_addr),  32'h50);
    chk("mr_wdata", 32'(mem_wdata), 32'h33);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_rst_we",    32'(mem_we),    32'd0);
    chk("mr_rst_addr",  32'(mem_addr),  32'd0);
    chk("mr_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mr_rst_ready", 32'(in_ready),  32'd0);
    chk("mr_rst_head",  32'(head),      32'd0);
    chk("mr_rst_count", 32'(count),     32'd0);
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mr_idle_ready", 32'(in_ready), 32'd0);
    chk("mr_idle_done",  32'(done),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
